// File: rtl/dl1_write_buffer_pkg.sv
// Shared types and default widths for the DL1 write buffer.
// The defaults here are the ones the L1/L2 write-back channel is built around;
// the modules take them as parameter defaults so a single edit retargets both.
package dl1_write_buffer_pkg;

    // Default data/address width and number of dropped byte-offset bits.
    localparam int DL1_DATA_LENGTH = 32;
    localparam int DL1_BYTE_OFFSET = 2;
    localparam int DL1_WB_DEPTH    = 8;
    localparam int DL1_WA          = DL1_DATA_LENGTH - DL1_BYTE_OFFSET;

    // One buffered store: word address plus full-word data.
    typedef struct packed {
        logic [DL1_WA-1:0]          addr;
        logic [DL1_DATA_LENGTH-1:0] data;
    } wb_entry_t;

    // Drain handshake state toward the L2 write buffer.
    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_REQ      = 2'd1,
        WB_WAIT_LOW = 2'd2
    } wb_state_e;

endpackage

// File: rtl/dl1_write_buffer_wb_fifo_mem.sv
// Entry storage for the DL1 write buffer: circular array with wrap-bit
// pointers, full/empty status, and a parallel address match that returns
// the data of the youngest matching entry for load forwarding.
module dl1_write_buffer_wb_fifo_mem
    import dl1_write_buffer_pkg::*;
#(
    parameter int WB_DEPTH    = DL1_WB_DEPTH,
    parameter int DATA_LENGTH = DL1_DATA_LENGTH,
    parameter int BYTE_OFFSET = DL1_BYTE_OFFSET
) (
    input  logic                                clk_l1,
    input  logic                                rst_n,
    input  logic                                push_en,
    input  logic                                coal_en,
    input  logic [DATA_LENGTH-BYTE_OFFSET-1:0]  push_addr,
    input  logic [DATA_LENGTH-1:0]              push_data,
    input  logic                                pop_en,
    input  logic [DATA_LENGTH-BYTE_OFFSET-1:0]  ld_word,
    output logic                                empty,
    output logic                                full,
    output logic                                one_entry,
    output logic [DATA_LENGTH-BYTE_OFFSET-1:0]  head_addr,
    output logic [DATA_LENGTH-1:0]              head_data,
    output logic [DATA_LENGTH-BYTE_OFFSET-1:0]  tail_addr,
    output logic                                fwd_hit,
    output logic [DATA_LENGTH-1:0]              fwd_data
);

    localparam int WA = DATA_LENGTH - BYTE_OFFSET;
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]          w_ptr_q, w_ptr_d;
    logic [CW-1:0]          r_ptr_q, r_ptr_d;
    logic [WA-1:0]          addr_q [WB_DEPTH];
    logic [WA-1:0]          addr_d [WB_DEPTH];
    logic [DATA_LENGTH-1:0] data_q [WB_DEPTH];
    logic [DATA_LENGTH-1:0] data_d [WB_DEPTH];

    logic [PW-1:0] w_idx;
    logic [PW-1:0] r_idx;
    logic [PW-1:0] tail_idx;
    logic [CW-1:0] count;
    logic [PW-1:0] fwd_idx;

    // Pointer views: low bits index the array, the extra MSB tells full from empty.
    always_comb begin
        w_idx     = w_ptr_q[PW-1:0];
        r_idx     = r_ptr_q[PW-1:0];
        tail_idx  = w_ptr_q[PW-1:0] - PW'(1);
        count     = w_ptr_q - r_ptr_q;
        empty     = (w_ptr_q == r_ptr_q);
        full      = (w_ptr_q[PW] != r_ptr_q[PW]) && (w_ptr_q[PW-1:0] == r_ptr_q[PW-1:0]);
        one_entry = (count == CW'(1));
        head_addr = addr_q[r_idx];
        head_data = data_q[r_idx];
        tail_addr = addr_q[tail_idx];
    end

    // Next pointers and array contents: push writes a new slot, coalesce rewrites the youngest.
    always_comb begin
        w_ptr_d = w_ptr_q + {{PW{1'b0}}, push_en};
        r_ptr_d = r_ptr_q + {{PW{1'b0}}, pop_en};
        addr_d  = addr_q;
        data_d  = data_q;
        if (push_en) begin
            addr_d[w_idx] = push_addr;
            data_d[w_idx] = push_data;
        end
        if (coal_en) begin
            data_d[tail_idx] = push_data;
        end
    end

    // Forwarding: walk valid entries oldest to youngest so the last hit is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            fwd_idx = r_idx + PW'(k);
            if ((CW'(k) < count) && (addr_q[fwd_idx] == ld_word)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    // Storage and pointer registers; reset empties the buffer.
    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dl1_write_buffer.sv
// DL1 write buffer: queues word stores from the L1 store path, merges a repeat
// store into the youngest entry, forwards buffered data to loads, and drains
// entries one at a time to the L2 write buffer.
//
// Store side: a store is taken on any posedge where store_req && store_ready;
// store_ready depends only on registered state (buffer not full).
// L2 side: 4-phase level handshake. wb_req rises with wb_data stable, L2 raises
// wb_ack, the entry is retired and wb_req falls, L2 drops wb_ack, and only then
// may the next wb_req rise.
module dl1_write_buffer
    import dl1_write_buffer_pkg::*;
#(
    parameter int WB_DEPTH    = DL1_WB_DEPTH,
    parameter int DATA_LENGTH = DL1_DATA_LENGTH,
    parameter int BYTE_OFFSET = DL1_BYTE_OFFSET
) (
    input  logic                                 clk_l1,
    input  logic                                 rst_n,
    input  logic                                 store_req,
    input  logic [DATA_LENGTH-1:0]               store_addr,
    input  logic [DATA_LENGTH-1:0]               store_data,
    output logic                                 store_ready,
    input  logic [DATA_LENGTH-1:0]               ld_addr,
    output logic                                 fwd_hit,
    output logic [DATA_LENGTH-1:0]               fwd_data,
    output logic                                 wb_req,
    output logic [2*DATA_LENGTH-BYTE_OFFSET-1:0] wb_data,
    input  logic                                 wb_ack,
    input  logic                                 full_flag,
    output logic                                 wb_empty,
    output wb_state_e                            dbg_state
);

    localparam int WA = DATA_LENGTH - BYTE_OFFSET;
    localparam int XW = 2*DATA_LENGTH - BYTE_OFFSET;

    wb_state_e     state_q, state_d;
    logic          wb_req_q, wb_req_d;
    logic [XW-1:0] wb_data_q, wb_data_d;

    logic [WA-1:0]          store_word;
    logic [WA-1:0]          ld_word;
    logic                   empty;
    logic                   full;
    logic                   one_entry;
    logic [WA-1:0]          head_addr;
    logic [DATA_LENGTH-1:0] head_data;
    logic [WA-1:0]          tail_addr;
    logic                   accept;
    logic                   launch;
    logic                   head_busy;
    logic                   coalesce;
    logic                   push;
    logic                   pop;
    logic                   unused_addr_lsbs;

    // Byte-offset bits take no part in word matching.
    always_comb begin
        store_word       = store_addr[DATA_LENGTH-1:BYTE_OFFSET];
        ld_word          = ld_addr[DATA_LENGTH-1:BYTE_OFFSET];
        unused_addr_lsbs = ^{store_addr[BYTE_OFFSET-1:0], ld_addr[BYTE_OFFSET-1:0]};
    end

    // Store acceptance and the coalesce/push decision.
    // The head is treated as busy while in REQ and also on the cycle it is being
    // latched into wb_data, so a merge can never land in data already sent.
    // After the ack the head has been retired, so WAIT_LOW does not block merging.
    always_comb begin
        store_ready = !full;
        accept      = store_req && store_ready;
        launch      = (state_q == WB_IDLE) && !empty && !full_flag;
        head_busy   = (state_q == WB_REQ) || launch;
        coalesce    = accept && !empty && (tail_addr == store_word) && !(one_entry && head_busy);
        push        = accept && !coalesce;
        pop         = (state_q == WB_REQ) && wb_ack;
        wb_empty    = empty && (state_q == WB_IDLE);
    end

    dl1_write_buffer_wb_fifo_mem #(
        .WB_DEPTH    (WB_DEPTH),
        .DATA_LENGTH (DATA_LENGTH),
        .BYTE_OFFSET (BYTE_OFFSET)
    ) u_fifo (
        .clk_l1    (clk_l1),
        .rst_n     (rst_n),
        .push_en   (push),
        .coal_en   (coalesce),
        .push_addr (store_word),
        .push_data (store_data),
        .pop_en    (pop),
        .ld_word   (ld_word),
        .empty     (empty),
        .full      (full),
        .one_entry (one_entry),
        .head_addr (head_addr),
        .head_data (head_data),
        .tail_addr (tail_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    // Drain FSM next state: latch the head, hold the request until ack, wait for ack low.
    always_comb begin
        state_d   = state_q;
        wb_req_d  = wb_req_q;
        wb_data_d = wb_data_q;
        unique case (state_q)
            WB_IDLE: begin
                if (!empty && !full_flag) begin
                    wb_data_d = {head_addr, head_data};
                    wb_req_d  = 1'b1;
                    state_d   = WB_REQ;
                end
            end
            WB_REQ: begin
                if (wb_ack) begin
                    wb_req_d = 1'b0;
                    state_d  = WB_WAIT_LOW;
                end
            end
            WB_WAIT_LOW: begin
                if (!wb_ack) begin
                    state_d = WB_IDLE;
                end
            end
            default: begin
                wb_req_d = 1'b0;
                state_d  = WB_IDLE;
            end
        endcase
    end

    // Drain FSM registers; reset drops wb_req at once.
    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WB_IDLE;
            wb_req_q  <= 1'b0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wb_req_q  <= wb_req_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_req    = wb_req_q;
    assign wb_data   = wb_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dl1_write_buffer.sv
// Bench for dl1_write_buffer: directed store sequences against an L2 responder,
// with a queue of expected transfers checked as each wb_req rises.
module tb_dl1_write_buffer;
    import dl1_write_buffer_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk_l1 = 1'b0;
    logic        rst_n;
    logic        store_req;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        store_ready;
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        wb_req;
    logic [61:0] wb_data;
    logic        wb_ack;
    logic        full_flag;
    logic        wb_empty;
    wb_state_e   dbg_state;

    always #5 clk_l1 = ~clk_l1;

    dl1_write_buffer #(
        .WB_DEPTH    (8),
        .DATA_LENGTH (32),
        .BYTE_OFFSET (2)
    ) dut (
        .clk_l1      (clk_l1),
        .rst_n       (rst_n),
        .store_req   (store_req),
        .store_addr  (store_addr),
        .store_data  (store_data),
        .store_ready (store_ready),
        .ld_addr     (ld_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .wb_req      (wb_req),
        .wb_data     (wb_data),
        .wb_ack      (wb_ack),
        .full_flag   (full_flag),
        .wb_empty    (wb_empty),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [61:0] exp_q[$];      // buffered entries not yet sent, oldest first
    logic [61:0] inflight_e;    // entry currently offered on wb_data
    int          in_fifo;       // 1 while the offered entry still occupies a slot
    int          l2_phase;      // 0 idle, 1 req seen, 2 ack high, 3 ack dropped
    int          l2_cnt;
    int          ack_delay;
    int          ack_hold;
    bit          ack_en;
    int          n_xfer;
    int          vectors;
    int          miscompares;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // L2 responder, stepped once per negedge.
    task automatic l2_step();
        int ph;
        ph = l2_phase;
        case (ph)
            0: begin
                if (wb_req) begin
                    if (exp_q.size() == 0) begin
                        check("req_with_empty_model", 64'(wb_req), 64'd0);
                        inflight_e = '0;
                    end else begin
                        inflight_e = exp_q.pop_front();
                        check("wb_data", 64'(wb_data), 64'(inflight_e));
                    end
                    in_fifo  = 1;
                    l2_phase = 1;
                    l2_cnt   = 0;
                end
            end
            1: check("req_held", 64'(wb_req), 64'd1);
            2: begin
                check("req_dropped", 64'(wb_req), 64'd0);
                in_fifo = 0;
                l2_cnt++;
                if (l2_cnt >= ack_hold) begin
                    wb_ack   = 1'b0;
                    l2_phase = 3;
                end
            end
            3: begin
                check("req_gap", 64'(wb_req), 64'd0);
                n_xfer++;
                l2_phase = 0;
            end
            default: l2_phase = 0;
        endcase
        if (l2_phase == 1 && ack_en) begin
            if (l2_cnt >= ack_delay) begin
                wb_ack   = 1'b1;
                l2_phase = 2;
                l2_cnt   = 0;
            end else begin
                l2_cnt++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_l1);
        l2_step();
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output bit acc);
        logic [61:0] e;
        bit          full_m;
        e      = {a[31:2], d};
        full_m = (exp_q.size() + in_fifo) >= 8;
        store_addr = a;
        store_data = d;
        store_req  = 1'b1;
        check("store_ready", 64'(store_ready), 64'(!full_m));
        acc = !full_m;
        if (acc) begin
            if (exp_q.size() > 0 && exp_q[$][61:32] == a[31:2]) exp_q[$] = e;
            else exp_q.push_back(e);
        end
        tick();
        store_req = 1'b0;
    endtask

    task automatic store1(input logic [31:0] a, input logic [31:0] d);
        bit acc;
        do_store(a, d, acc);
    endtask

    task automatic check_fwd(input string tag, input logic [31:0] a);
        bit          hit;
        logic [31:0] d;
        hit = 1'b0;
        d   = '0;
        ld_addr = a;
        #1;
        if (in_fifo != 0 && inflight_e[61:32] == a[31:2]) begin
            hit = 1'b1;
            d   = inflight_e[31:0];
        end
        foreach (exp_q[i]) begin
            if (exp_q[i][61:32] == a[31:2]) begin
                hit = 1'b1;
                d   = exp_q[i][31:0];
            end
        end
        check({tag, "_hit"}, 64'(fwd_hit), 64'(hit));
        if (hit) check({tag, "_data"}, 64'(fwd_data), 64'(d));
    endtask

    task automatic wait_launch(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            tick();
            if (l2_phase != 0) done = 1'b1;
        end
        check({tag, "_launch_seen"}, 64'(done), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            tick();
            if (l2_phase == 0 && exp_q.size() == 0 && in_fifo == 0) done = 1'b1;
        end
        check({tag, "_drained"}, 64'(done), 64'd1);
        check({tag, "_wb_empty"}, 64'(wb_empty), 64'd1);
    endtask

    task automatic reset_model();
        exp_q.delete();
        in_fifo    = 0;
        l2_phase   = 0;
        l2_cnt     = 0;
        inflight_e = '0;
        wb_ack     = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int x0;
        bit acc;
        vectors = 0; miscompares = 0; n_xfer = 0;
        ack_delay = 0; ack_hold = 1; ack_en = 1'b1;
        store_req = 1'b0; store_addr = '0; store_data = '0;
        ld_addr = '0; full_flag = 1'b0;
        reset_model();
        rst_n = 1'b0;
        #1;
        check("rst_wb_req", 64'(wb_req), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_store_ready", 64'(store_ready), 64'd1);
        check("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        check("rst_wb_empty", 64'(wb_empty), 64'd1);
        check("rst_state", 64'(dbg_state), 64'(WB_IDLE));
        @(negedge clk_l1);
        @(negedge clk_l1);
        rst_n = 1'b1;
        tick();

        // 1: single store, latency, ack held 3 cycles
        ack_hold = 3;
        x0 = n_xfer;
        store1(32'h0000_0100, 32'h0000_1110);
        check("t1_req_not_yet", 64'(wb_req), 64'd0);
        check_fwd("t1_fwd", 32'h0000_0100);
        tick();
        check("t1_req_up", 64'(wb_req), 64'd1);
        check("t1_data", 64'(wb_data), 64'({30'h40, 32'h0000_1110}));
        wait_idle("t1");
        check("t1_xfers", 64'(n_xfer - x0), 64'd1);
        ack_hold = 1;

        // 2: fill to full with L2 stalled, reject the 9th, free one slot
        ack_en = 1'b0;
        for (int i = 0; i < 8; i++) store1(32'(i * 4), 32'hA000 + 32'(i));
        check("t2_full", 64'(store_ready), 64'd0);
        do_store(32'h0000_0020, 32'h0000_0099, acc);
        ack_en = 1'b1;
        tick();
        tick();
        check("t2_ready_after_ack", 64'(store_ready), 64'd1);
        wait_idle("t2");

        // 3a: back-to-back same word behind a busy older entry merges
        x0 = n_xfer;
        ack_en = 1'b0;
        store1(32'h0000_0200, 32'h0000_0005);
        wait_launch("t3a");
        store1(32'h0000_0040, 32'h0000_AAAA);
        store1(32'h0000_0040, 32'h0000_BBBB);
        check_fwd("t3a_fwd", 32'h0000_0040);
        ack_en = 1'b1;
        wait_idle("t3a");
        check("t3a_xfers", 64'(n_xfer - x0), 64'd2);

        // 3b: same word as the in-flight head gets its own entry
        x0 = n_xfer;
        ack_en = 1'b0;
        store1(32'h0000_0040, 32'h0000_AAAA);
        wait_launch("t3b");
        store1(32'h0000_0040, 32'h0000_BBBB);
        check_fwd("t3b_fwd", 32'h0000_0040);
        ack_en = 1'b1;
        wait_idle("t3b");
        check("t3b_xfers", 64'(n_xfer - x0), 64'd2);

        // 4: forwarding picks the youngest match
        full_flag = 1'b1;
        store1(32'h0000_0080, 32'h1);
        store1(32'h0000_0084, 32'h2);
        store1(32'h0000_0080, 32'h3);
        check_fwd("t4_fwd82", 32'h0000_0082);
        check("t4_fwd_data_const", 64'(fwd_data), 64'd3);
        check_fwd("t4_fwd88", 32'h0000_0088);
        check("t4_miss_const", 64'(fwd_hit), 64'd0);

        // 5: full_flag blocks launch, then three ordered transfers
        x0 = n_xfer;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_blocked", 64'(wb_req), 64'd0);
        end
        full_flag = 1'b0;
        wait_idle("t5");
        check("t5_xfers", 64'(n_xfer - x0), 64'd3);

        // 5b: full_flag rising mid-request does not drop wb_req
        ack_en = 1'b0;
        store1(32'h0000_0300, 32'h7);
        wait_launch("t5b");
        full_flag = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ack_en = 1'b1;
        wait_idle("t5b");
        full_flag = 1'b0;

        // 6: 20 stores through a continuously acking L2, across pointer wrap
        x0 = n_xfer;
        for (int i = 0; i < 20; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) do_store(32'h1000 + 32'(i * 4), $urandom, acc);
            check("t6_store_taken", 64'(acc), 64'd1);
        end
        wait_idle("t6");
        check("t6_xfers", 64'(n_xfer - x0), 64'd20);

        // 6b: reset during REQ
        ack_en = 1'b0;
        store1(32'h0000_0500, 32'h9);
        wait_launch("t6b");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6b_rst_req", 64'(wb_req), 64'd0);
        reset_model();
        @(negedge clk_l1);
        rst_n = 1'b1;
        tick();
        check("t6b_wb_empty", 64'(wb_empty), 64'd1);
        check("t6b_ready", 64'(store_ready), 64'd1);
        check_fwd("t6b_fwd", 32'h0000_0500);
        ack_en = 1'b1;
        store1(32'h0000_0600, 32'h0000_0ABC);
        wait_idle("t6b_post");

        check("exp_q_leftover", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
